pipo_arbiter: RTL and testbench

PIPO_ARBITER -- requirements
Module: pipo_arbiter

---
 rtl/pipo_arbiter.sv | 122 ++++++++++++
 tb/tb_pipo_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipo_arbiter.sv
// pipo_arbiter: four requesters share one 4-bit parallel-in parallel-out
// register through a round-robin arbiter with a two-state FSM (IDLE, HOLD).
//
// Parameters
//   HOLD_CYCLES  cycles a grant is held after each load (1..15)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   req[3:0]     req[i] asks to load requester i's data slice
//   req_data     requester i data on req_data[4i+3:4i]
//   lock[3:0]    owner asks to keep ownership (only with PIPO_ARB_LOCK_EN)
//   data_out     shared register contents
//   gnt          one-hot current owner, zero when idle
//   ack          one-cycle one-hot pulse in the cycle after a load
//   busy         high while in HOLD
//
// Build option
//   PIPO_ARB_LOCK_EN  when defined, an owner holding lock and req at the end
//                     of its hold reloads and keeps the grant; otherwise the
//                     lock port is ignored.
module pipo_arbiter #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] req_data,
   input  logic [3:0]  lock,
   output logic [3:0]  data_out,
   output logic [3:0]  gnt,
   output logic [3:0]  ack,
   output logic        busy
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

   state_t          state;
   logic [3:0]      cnt;
   logic [1:0]      rr_ptr;
   logic [1:0]      owner;
   logic [3:0][3:0] slice;
   logic [1:0]      win;
   logic            win_vld;
   logic            reload;

   assign slice = req_data;

   // Round-robin pick: scan offsets high to low so the smallest offset
   // from rr_ptr (with 2-bit wrap) is the last to overwrite win.
   always_comb begin
      logic [1:0] idx;
      idx     = 2'd0;
      win     = rr_ptr;
      win_vld = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_ptr + 2'(k);
         if (req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

`ifdef PIPO_ARB_LOCK_EN
   // Only the owner's lock/req pair matters; other lock bits are ignored.
   assign reload = lock[owner] & req[owner];
`else
   logic unused_lock;
   assign unused_lock = ^lock;
   assign reload      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         rr_ptr   <= 2'd0;
         owner    <= 2'd0;
         data_out <= 4'd0;
         gnt      <= 4'd0;
         ack      <= 4'd0;
         busy     <= 1'b0;
      end else begin
         // ack is a single-cycle pulse unless a load happens this edge
         ack <= 4'd0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  data_out <= slice[win];
                  gnt      <= 4'b0001 << win;
                  ack      <= 4'b0001 << win;
                  owner    <= win;
                  cnt      <= CNT_INIT;
                  busy     <= 1'b1;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               // req is not looked at until the hold expires, so an owner
               // withdrawing early cannot shorten it
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (reload) begin
                  data_out <= slice[owner];
                  ack      <= gnt;
                  cnt      <= CNT_INIT;
               end else begin
                  gnt    <= 4'd0;
                  busy   <= 1'b0;
                  rr_ptr <= owner + 2'd1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipo_arbiter.sv
// Directed bench for pipo_arbiter: a HOLD_CYCLES=2 instance carries the
// main sequence, a HOLD_CYCLES=1 instance shares its inputs for the
// single-cycle hold case.
module tb_pipo_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  lock;
   logic [3:0]  data_out, gnt, ack;
   logic        busy;
   logic [3:0]  d1, g1, a1;
   logic        b1;

   int n_tests = 0;
   int n_fail  = 0;

   pipo_arbiter #(.HOLD_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .lock(lock),
      .data_out(data_out), .gnt(gnt), .ack(ack), .busy(busy)
   );

   pipo_arbiter #(.HOLD_CYCLES(1)) u_h1 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .lock(lock),
      .data_out(d1), .gnt(g1), .ack(a1), .busy(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one rising edge, then settle 1 time unit before sampling/driving
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; req = 4'd0; req_data = 16'd0; lock = 4'd0;
      tick; tick;
      check("rst_data", 16'(data_out), 16'h0);
      check("rst_gnt",  16'(gnt),      16'h0);
      check("rst_ack",  16'(ack),      16'h0);
      check("rst_busy", 16'(busy),     16'h0);

      // single request from 2, then wrap-around back to 0
      rst = 1'b1; req = 4'b0100; req_data = 16'h0A00;
      tick;
      check("r2_data", 16'(data_out), 16'hA);
      check("r2_gnt",  16'(gnt),      16'h4);
      check("r2_ack",  16'(ack),      16'h4);
      check("r2_busy", 16'(busy),     16'h1);
      check("h1_gnt",  16'(g1),       16'h4);
      check("h1_busy", 16'(b1),       16'h1);
      req = 4'b0000;
      tick;
      check("r2_ack_off", 16'(ack),  16'h0);
      check("r2_busy2",   16'(busy), 16'h1);
      check("r2_gnt2",    16'(gnt),  16'h4);
      check("h1_gnt_off", 16'(g1),   16'h0);
      check("h1_busy_off",16'(b1),   16'h0);
      check("h1_data",    16'(d1),   16'hA);
      tick;
      check("r2_idle_busy", 16'(busy),     16'h0);
      check("r2_idle_gnt",  16'(gnt),      16'h0);
      check("r2_idle_data", 16'(data_out), 16'hA);
      tick;
      check("idle_hold_data", 16'(data_out), 16'hA);
      req = 4'b0101; req_data = 16'h0605;
      tick;
      check("wrap_gnt",  16'(gnt),      16'h1);
      check("wrap_data", 16'(data_out), 16'h5);
      req = 4'b0000;
      tick; tick;

      // full round robin with req held at 1111 from a fresh reset
      rst = 1'b0;
      tick;
      rst = 1'b1; req = 4'b1111; req_data = 16'h4321;
      for (int i = 0; i < 5; i++) begin
         tick;
         check("rr_gnt",  16'(gnt),      16'(4'b0001 << (i % 4)));
         check("rr_data", 16'(data_out), 16'((i % 4) + 1));
         check("rr_ack",  16'(ack),      16'(4'b0001 << (i % 4)));
         tick;
         check("rr_ack_off", 16'(ack),  16'h0);
         check("rr_busy",    16'(busy), 16'h1);
         tick;
         check("rr_idle_gnt",  16'(gnt),  16'h0);
         check("rr_idle_busy", 16'(busy), 16'h0);
      end

      // reset dropped between edges in the middle of a hold
      tick;
      check("ab_gnt", 16'(gnt), 16'h2);
      #2 rst = 1'b0;
      #1;
      check("ab_data", 16'(data_out), 16'h0);
      check("ab_gnt0", 16'(gnt),      16'h0);
      check("ab_ack0", 16'(ack),      16'h0);
      check("ab_busy", 16'(busy),     16'h0);
      req = 4'b0000;
      tick;
      rst = 1'b1;
      tick;
      check("ab_post_ack", 16'(ack), 16'h0);
      check("ab_post_gnt", 16'(gnt), 16'h0);
      tick;
      check("ab_post_ack2", 16'(ack), 16'h0);

      // owner withdraws req right after grant: full hold anyway
      req = 4'b0010; req_data = 16'h0070;
      tick;
      check("wd_gnt",  16'(gnt),      16'h2);
      check("wd_data", 16'(data_out), 16'h7);
      req = 4'b0000;
      tick;
      check("wd_gnt_held", 16'(gnt),      16'h2);
      check("wd_busy",     16'(busy),     16'h1);
      check("wd_data2",    16'(data_out), 16'h7);
      tick;
      check("wd_release", 16'(gnt),      16'h0);
      check("wd_data3",   16'(data_out), 16'h7);

      // lock: owner 1 locked with 0 also requesting
      req = 4'b0010; req_data = 16'h0093; lock = 4'b0010;
      tick;
      check("lk_gnt", 16'(gnt), 16'h2);
      check("lk_ack", 16'(ack), 16'h2);
      req = 4'b0011;
      tick;
      check("lk_ack_off", 16'(ack), 16'h0);
      tick;
`ifdef PIPO_ARB_LOCK_EN
      check("lk_reload_gnt",  16'(gnt),      16'h2);
      check("lk_reload_ack",  16'(ack),      16'h2);
      check("lk_reload_data", 16'(data_out), 16'h9);
      tick;
      check("lk_ack_off2", 16'(ack), 16'h0);
      tick;
      check("lk_reload_ack2", 16'(ack), 16'h2);
      check("lk_reload_gnt2", 16'(gnt), 16'h2);
      lock = 4'b0000;
      tick;
      tick;
      check("lk_release", 16'(gnt), 16'h0);
      tick;
`else
      check("nolk_release", 16'(gnt), 16'h0);
      check("nolk_ack",     16'(ack), 16'h0);
      tick;
`endif
      check("lk_next_gnt",  16'(gnt),      16'h1);
      check("lk_next_data", 16'(data_out), 16'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
